// File: rtl/utopia2_atm_tx_if.sv
// Utopia level 2 transmit bundle: word-wide cell input from the ATM core plus the
// PHY-side transmit bus. The transmitter is the master of the Utopia bus.
interface utopia2_atm_tx_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_soc;
  logic [4:0]       in_phy;
  logic [WIDTH-1:0] tx_data;
  logic             tx_soc;
  logic             tx_enb;
  logic [4:0]       tx_addr;
  logic             tx_clav;

  modport master (input  in_valid, in_data, in_soc, in_phy, tx_clav,
                  output in_ready, tx_data, tx_soc, tx_enb, tx_addr);
  modport slave  (output in_valid, in_data, in_soc, in_phy, tx_clav,
                  input  in_ready, tx_data, tx_soc, tx_enb, tx_addr);
endinterface

// File: rtl/utopia2_atm_tx.sv
// Utopia level 2 ATM-layer transmitter: buffers whole cells, polls the head cell's
// PHY for clav and then transmits the cell on the shared Utopia bus.
//
//   state  | meaning
//   IDLE   | no committed cell in the buffer
//   POLL   | head PHY address driven with tx_enb high
//   CHECK  | null address driven, tx_clav sampled
//   SELECT | head PHY address driven to select it for transfer
//   SEND   | one cell word per cycle with tx_enb low
module utopia2_atm_tx #(
  parameter int WIDTH   = 8,
  parameter int NUM_PHY = 4,
  parameter int DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  utopia2_atm_tx_if.master    bus,
  output logic                err_runt,
  output logic [15:0]         cells_sent
);
  localparam int CW = (WIDTH == 8) ? 53 : 27;
  localparam int IW = $clog2(CW);
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [4:0] NULL_ADDR = 5'h1F;

  typedef enum logic [2:0] {IDLE, POLL, CHECK, SELECT, SEND} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH][CW];
  logic [4:0]       phy_mem [DEPTH];
  logic [SW-1:0]    wr_slot, rd_slot, rd_next;
  logic [NW-1:0]    count, count_nxt;
  logic [IW-1:0]    wr_idx, wr_pos, rd_idx, rd_inc;
  logic             open_cell;
  logic             take, wr_en, commit, pop, runt;
  logic [WIDTH-1:0] tx_data_q;
  logic             tx_soc_q, tx_enb_q;
  logic [4:0]       tx_addr_q;

  assign bus.in_ready = !reset && (count != NW'(DEPTH));
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_soc   = tx_soc_q;
  assign bus.tx_enb   = tx_enb_q;
  assign bus.tx_addr  = tx_addr_q;

  assign take    = bus.in_valid && bus.in_ready;
  assign wr_en   = take && (bus.in_soc || open_cell);
  assign wr_pos  = bus.in_soc ? '0 : wr_idx;
  assign runt    = take && bus.in_soc && open_cell;
  // Cells for out-of-range PHYs are assembled normally but never committed.
  assign commit  = take && open_cell && !bus.in_soc && (wr_idx == IW'(CW - 1))
                   && (phy_mem[wr_slot] < 5'(NUM_PHY));
  assign pop     = (state == SEND) && (rd_idx == IW'(CW - 1));
  assign count_nxt = count + NW'(commit) - NW'(pop);
  assign rd_next = rd_slot + 1'b1;
  assign rd_inc  = rd_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_slot][wr_pos] <= bus.in_data;
      if (bus.in_soc) phy_mem[wr_slot] <= bus.in_phy;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      open_cell <= 1'b0;
      wr_idx    <= '0;
      wr_slot   <= '0;
      err_runt  <= 1'b0;
    end else begin
      err_runt <= runt;
      if (wr_en) begin
        if (bus.in_soc) begin
          open_cell <= 1'b1;
          wr_idx    <= IW'(1);
        end else if (wr_idx == IW'(CW - 1)) begin
          open_cell <= 1'b0;
          wr_idx    <= '0;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (commit) wr_slot <= wr_slot + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_slot    <= '0;
      rd_idx     <= '0;
      count      <= '0;
      cells_sent <= '0;
      tx_data_q  <= '0;
      tx_soc_q   <= 1'b0;
      tx_enb_q   <= 1'b1;
      tx_addr_q  <= NULL_ADDR;
    end else begin
      count <= count_nxt;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= POLL;
            tx_addr_q <= phy_mem[rd_slot];
          end
        end
        POLL: begin
          state     <= CHECK;
          tx_addr_q <= NULL_ADDR;
        end
        CHECK: begin
          // A busy PHY keeps the head cell; later cells wait behind it.
          state     <= bus.tx_clav ? SELECT : POLL;
          tx_addr_q <= phy_mem[rd_slot];
        end
        SELECT: begin
          state     <= SEND;
          tx_enb_q  <= 1'b0;
          tx_addr_q <= NULL_ADDR;
          tx_data_q <= mem[rd_slot][0];
          tx_soc_q  <= 1'b1;
          rd_idx    <= '0;
        end
        SEND: begin
          tx_soc_q <= 1'b0;
          if (pop) begin
            tx_enb_q   <= 1'b1;
            tx_data_q  <= '0;
            rd_idx     <= '0;
            rd_slot    <= rd_next;
            cells_sent <= cells_sent + 16'd1;
            if (count_nxt != '0) begin
              state     <= POLL;
              tx_addr_q <= phy_mem[rd_next];
            end else begin
              state <= IDLE;
            end
          end else begin
            tx_data_q <= mem[rd_slot][rd_inc];
            rd_idx    <= rd_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_utopia2_atm_tx.sv
// Directed bench for the Utopia 2 transmitter: an 8-bit instance (a) for most cases
// and a 16-bit instance (b) for the 27-word cell and out-of-range PHY drop.
module tb_utopia2_atm_tx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  utopia2_atm_tx_if #(.WIDTH(8))  ia ();
  utopia2_atm_tx_if #(.WIDTH(16)) ib ();
  logic        err_runt_a, err_runt_b;
  logic [15:0] sent_a, sent_b;

  utopia2_atm_tx #(.WIDTH(8), .NUM_PHY(4), .DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ia.master),
    .err_runt(err_runt_a), .cells_sent(sent_a));
  utopia2_atm_tx #(.WIDTH(16), .NUM_PHY(4), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ib.master),
    .err_runt(err_runt_b), .cells_sent(sent_b));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bus monitor: {soc, data} of every SEND word, addressed PHY per cell, activity counts
  logic [16:0] rx_a[$];
  logic [16:0] rx_b[$];
  logic [4:0]  phy_a[$];
  logic [4:0]  last_addr_a = 5'h1F;
  int poll_a = 0, act_a = 0, runt_a = 0, acc_a = 0, act_b = 0;

  always @(posedge clk) begin
    if (ia.in_valid && ia.in_ready) acc_a++;
    #1;
    if (ia.tx_enb == 1'b0) rx_a.push_back({ia.tx_soc, 8'h00, ia.tx_data});
    if (ia.tx_enb == 1'b0 && ia.tx_soc) phy_a.push_back(last_addr_a);
    if (ia.tx_enb == 1'b1 && ia.tx_addr != 5'h1F) begin
      poll_a++;
      last_addr_a = ia.tx_addr;
    end
    if (ia.tx_enb == 1'b0 || ia.tx_addr != 5'h1F) act_a++;
    if (err_runt_a) runt_a++;
    if (ib.tx_enb == 1'b0) rx_b.push_back({ib.tx_soc, ib.tx_data});
    if (ib.tx_enb == 1'b0 || ib.tx_addr != 5'h1F) act_b++;
  end

  task automatic put_a(input logic [7:0] d, input logic soc, input logic [4:0] phy);
    int t = 0;
    ia.in_valid = 1'b1; ia.in_data = d; ia.in_soc = soc; ia.in_phy = phy;
    while (!ia.in_ready && t < 3000) begin @(negedge clk); t++; end
    if (!ia.in_ready) chk("in_ready_wait_a", ia.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    ia.in_valid = 1'b0; ia.in_soc = 1'b0;
  endtask

  task automatic put_b(input logic [15:0] d, input logic soc, input logic [4:0] phy);
    int t = 0;
    ib.in_valid = 1'b1; ib.in_data = d; ib.in_soc = soc; ib.in_phy = phy;
    while (!ib.in_ready && t < 3000) begin @(negedge clk); t++; end
    if (!ib.in_ready) chk("in_ready_wait_b", ib.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    ib.in_valid = 1'b0; ib.in_soc = 1'b0;
  endtask

  task automatic cell_a(input logic [4:0] phy, input logic [7:0] base);
    for (int i = 0; i < 53; i++) put_a(base + 8'(i), i == 0, phy);
  endtask

  task automatic cell_b(input logic [4:0] phy, input logic [15:0] base);
    for (int i = 0; i < 27; i++) put_b(base + 16'(i), i == 0, phy);
  endtask

  task automatic expect_cell_a(input string tag, input logic [4:0] phy, input logic [7:0] base);
    logic [16:0] w;
    int bad = 0;
    if (rx_a.size() < 53) chk({tag, "_len"}, rx_a.size(), 53);
    else begin
      if (phy_a.size() != 0) chk({tag, "_phy"}, phy_a.pop_front(), phy);
      else chk({tag, "_phy_cnt"}, phy_a.size(), 1);
      for (int i = 0; i < 53; i++) begin
        w = rx_a.pop_front();
        if (i == 0) begin
          chk({tag, "_first"}, w[7:0], base);
          chk({tag, "_soc"}, w[16], 1'b1);
        end else if (w[16] !== 1'b0 || w[7:0] !== base + 8'(i)) bad++;
        if (i == 52) chk({tag, "_last"}, w[7:0], base + 8'd52);
      end
      chk({tag, "_bad_words"}, bad, 0);
    end
  endtask

  task automatic wait_sent_a(input logic [15:0] n);
    int t = 0;
    while (sent_a != n && t < 4000) begin @(negedge clk); t++; end
    chk("sent_a", sent_a, n);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rx_a.delete(); rx_b.delete(); phy_a.delete();
    poll_a = 0; act_a = 0; runt_a = 0; acc_a = 0; act_b = 0;
  endtask

  initial begin
    logic [16:0] w;
    int t;
    int bad;
    reset = 1'b1;
    ia.in_valid = 1'b0; ia.in_data = '0; ia.in_soc = 1'b0; ia.in_phy = '0; ia.tx_clav = 1'b0;
    ib.in_valid = 1'b0; ib.in_data = '0; ib.in_soc = 1'b0; ib.in_phy = '0; ib.tx_clav = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", ia.in_ready, 1'b0);
    chk("rst_tx_enb", ia.tx_enb, 1'b1);
    chk("rst_tx_addr", ia.tx_addr, 5'h1F);
    chk("rst_tx_data", ia.tx_data, 8'h00);
    chk("rst_tx_soc", ia.tx_soc, 1'b0);
    chk("rst_err_runt", err_runt_a, 1'b0);
    chk("rst_cells_sent", sent_a, 16'd0);
    chk("rst_b_tx_enb", ib.tx_enb, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", ia.in_ready, 1'b1);

    // one cell to PHY 2, clav always high: check cycle-exact latency and framing
    ia.tx_clav = 1'b1;
    cell_a(5'd2, 8'h00);
    chk("t1_visible_addr", ia.tx_addr, 5'h1F);
    chk("t1_visible_enb", ia.tx_enb, 1'b1);
    @(negedge clk);
    chk("t1_poll_addr", ia.tx_addr, 5'd2);
    chk("t1_poll_enb", ia.tx_enb, 1'b1);
    @(negedge clk);
    chk("t1_check_addr", ia.tx_addr, 5'h1F);
    @(negedge clk);
    chk("t1_select_addr", ia.tx_addr, 5'd2);
    chk("t1_select_enb", ia.tx_enb, 1'b1);
    @(negedge clk);
    chk("t1_send_enb", ia.tx_enb, 1'b0);
    chk("t1_send_soc", ia.tx_soc, 1'b1);
    chk("t1_send_data", ia.tx_data, 8'h00);
    chk("t1_send_addr", ia.tx_addr, 5'h1F);
    repeat (52) @(negedge clk);
    chk("t1_last_data", ia.tx_data, 8'h34);
    chk("t1_last_soc", ia.tx_soc, 1'b0);
    chk("t1_last_enb", ia.tx_enb, 1'b0);
    @(negedge clk);
    chk("t1_after_enb", ia.tx_enb, 1'b1);
    chk("t1_after_data", ia.tx_data, 8'h00);
    chk("t1_sent", sent_a, 16'd1);
    expect_cell_a("t1", 5'd2, 8'h00);
    chk("t1_extra_words", rx_a.size(), 0);

    // three refused polls before clav rises
    do_reset();
    ia.tx_clav = 1'b0;
    cell_a(5'd1, 8'h40);
    t = 0;
    while (poll_a < 3 && t < 200) begin @(negedge clk); t++; end
    chk("t2_polls_seen", poll_a, 3);
    @(negedge clk);
    @(negedge clk);
    ia.tx_clav = 1'b1;
    wait_sent_a(16'd1);
    chk("t2_poll_select_cnt", poll_a, 5);
    expect_cell_a("t2", 5'd1, 8'h40);
    chk("t2_extra_words", rx_a.size(), 0);

    // full buffer: fifth cell held off until the head cell is popped
    do_reset();
    ia.tx_clav = 1'b0;
    cell_a(5'd0, 8'h00);
    cell_a(5'd1, 8'h10);
    cell_a(5'd2, 8'h20);
    cell_a(5'd3, 8'h30);
    chk("t3_full_in_ready", ia.in_ready, 1'b0);
    fork
      cell_a(5'd1, 8'h50);
      begin
        repeat (30) @(negedge clk);
        chk("t3_still_blocked", ia.in_ready, 1'b0);
        chk("t3_words_accepted", acc_a, 4 * 53);
        chk("t3_no_send", sent_a, 16'd0);
        ia.tx_clav = 1'b1;
      end
    join
    wait_sent_a(16'd5);
    expect_cell_a("t3_c0", 5'd0, 8'h00);
    expect_cell_a("t3_c1", 5'd1, 8'h10);
    expect_cell_a("t3_c2", 5'd2, 8'h20);
    expect_cell_a("t3_c3", 5'd3, 8'h30);
    expect_cell_a("t3_c4", 5'd1, 8'h50);

    // orphan word ignored, then in_soc on word 20 restarts the cell
    do_reset();
    ia.tx_clav = 1'b1;
    put_a(8'hEE, 1'b0, 5'd3);
    chk("t4_orphan_no_runt", runt_a, 0);
    for (int i = 0; i < 19; i++) put_a(8'hA0 + 8'(i), i == 0, 5'd3);
    cell_a(5'd3, 8'h55);
    wait_sent_a(16'd1);
    chk("t4_runt_pulses", runt_a, 1);
    expect_cell_a("t4", 5'd3, 8'h55);
    chk("t4_extra_words", rx_a.size(), 0);

    // 16-bit: 27-word cell to PHY 0, then a cell to PHY 7 that must be dropped
    do_reset();
    ib.tx_clav = 1'b1;
    cell_b(5'd0, 16'h1000);
    cell_b(5'd7, 16'h2000);
    t = 0;
    while (sent_b != 16'd1 && t < 500) begin @(negedge clk); t++; end
    repeat (60) @(negedge clk);
    chk("t5_sent_b", sent_b, 16'd1);
    chk("t5_activity_b", act_b, 29);
    chk("t5_len_b", rx_b.size(), 27);
    if (rx_b.size() == 27) begin
      bad = 0;
      for (int i = 0; i < 27; i++) begin
        w = rx_b[i];
        if (w[16] !== (i == 0) || w[15:0] !== 16'h1000 + 16'(i)) bad++;
      end
      w = rx_b[0];
      chk("t5_first_b", w[15:0], 16'h1000);
      w = rx_b[26];
      chk("t5_last_b", w[15:0], 16'h101A);
      chk("t5_bad_words_b", bad, 0);
    end
    chk("t5_in_ready_b", ib.in_ready, 1'b1);

    // reset in the middle of SEND truncates the cell silently
    do_reset();
    ia.tx_clav = 1'b1;
    cell_a(5'd2, 8'h80);
    t = 0;
    while (!(ia.tx_enb == 1'b0 && ia.tx_soc) && t < 50) begin @(negedge clk); t++; end
    chk("t6_soc_seen", ia.tx_soc, 1'b1);
    repeat (9) @(negedge clk);
    chk("t6_word10", ia.tx_data, 8'h89);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_enb", ia.tx_enb, 1'b1);
    chk("t6_rst_addr", ia.tx_addr, 5'h1F);
    chk("t6_rst_data", ia.tx_data, 8'h00);
    chk("t6_rst_soc", ia.tx_soc, 1'b0);
    chk("t6_rst_sent", sent_a, 16'd0);
    chk("t6_rst_in_ready", ia.in_ready, 1'b0);
    reset = 1'b0;
    act_a = 0;
    runt_a = 0;
    @(negedge clk);
    chk("t6_in_ready", ia.in_ready, 1'b1);
    repeat (20) @(negedge clk);
    chk("t6_quiet", act_a, 0);
    chk("t6_no_runt", runt_a, 0);
    chk("t6_sent_after", sent_a, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
